// File: rtl/vend_ctrl_if.sv
// Signal bundle between the vending controller (slave) and its coin acceptor,
// selection keys, dispenser and change hopper (master side).
interface vend_ctrl_if;
  logic       coin_5;
  logic       coin_10;
  logic       sel_a;
  logic       sel_b;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic       chg_req;
  logic       coin_reject;
  logic [4:0] credit;
  logic       busy;
  logic       fault;

  modport master (
    output coin_5, coin_10, sel_a, sel_b, cancel, disp_ack, chg_ack,
    input  disp_req, chg_req, coin_reject, credit, busy, fault
  );

  modport slave (
    input  coin_5, coin_10, sel_a, sel_b, cancel, disp_ack, chg_ack,
    output disp_req, chg_req, coin_reject, credit, busy, fault
  );
endinterface

// File: rtl/vend_ctrl.sv
// Two-product vending controller: credit accumulation, sale, change payout.
// Define VEND_DISP_TMO_EN to add the dispense-ack watchdog and FAULT lockout.
module vend_ctrl #(
  parameter int PRICE_A  = 15,
  parameter int PRICE_B  = 20,
  parameter int DISP_TMO = 63
) (
  input  logic       clk,
  input  logic       reset,
  vend_ctrl_if.slave bus
);

  if (PRICE_A < 5 || PRICE_A > 30 || (PRICE_A % 5) != 0 ||
      PRICE_B < 5 || PRICE_B > 30 || (PRICE_B % 5) != 0 ||
      DISP_TMO < 1) begin : g_param_chk
    $error("vend_ctrl: prices must be multiples of 5 in 5..30 and DISP_TMO >= 1");
  end

  localparam logic [5:0] CREDIT_MAX = 6'd30;
  localparam logic [5:0] PRICE_A_W  = 6'(PRICE_A);
  localparam logic [5:0] PRICE_B_W  = 6'(PRICE_B);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE,
    FAULT
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic       disp_req_q, disp_req_d;
  logic       chg_req_q, chg_req_d;
  logic       coin_reject_q, coin_reject_d;
  logic       busy_q, busy_d;

  logic [5:0] coin_sum;
  logic [5:0] credit_add;
  logic       coin_any;
  logic       coin_fits;
  logic       tmo_hit;

  always_comb begin
    coin_sum   = (bus.coin_5 ? 6'd5 : 6'd0) + (bus.coin_10 ? 6'd10 : 6'd0);
    credit_add = {1'b0, credit_q} + coin_sum;
    coin_any   = bus.coin_5 | bus.coin_10;
    coin_fits  = (credit_add <= CREDIT_MAX);
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;

    unique case (state_q)
      IDLE, COLLECT: begin
        if (coin_fits) credit_d = credit_add[4:0];
        else           coin_reject_d = 1'b1;

        // Selections are priced against the credit including this cycle's coins.
        if (state_q == IDLE) begin
          if (credit_d != 5'd0) state_d = COLLECT;
        end else if (bus.sel_a && ({1'b0, credit_d} >= PRICE_A_W)) begin
          credit_d = credit_d - PRICE_A_W[4:0];
          state_d  = DISPENSE;
        end else if (bus.sel_b && ({1'b0, credit_d} >= PRICE_B_W)) begin
          credit_d = credit_d - PRICE_B_W[4:0];
          state_d  = DISPENSE;
        end else if (bus.cancel) begin
          state_d = CHANGE;
        end
      end

      DISPENSE: begin
        coin_reject_d = coin_any;
        if (bus.disp_ack && disp_req_q) begin
          state_d = (credit_q != 5'd0) ? CHANGE : IDLE;
        end else if (tmo_hit) begin
          state_d = FAULT;
        end
      end

      CHANGE: begin
        coin_reject_d = coin_any;
        if (bus.chg_ack && chg_req_q) begin
          credit_d = credit_q - 5'd5;
          if (credit_d == 5'd0) state_d = IDLE;
        end
      end

      FAULT: begin
        coin_reject_d = coin_any;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    disp_req_d = (state_d == DISPENSE);
    chg_req_d  = (state_d == CHANGE) && (credit_d != 5'd0);
    busy_d     = (state_d == DISPENSE) || (state_d == CHANGE) || (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      credit_q      <= 5'd0;
      disp_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      chg_req_q     <= chg_req_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

`ifdef VEND_DISP_TMO_EN
  localparam int TMO_W = (DISP_TMO > 1) ? $clog2(DISP_TMO) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;

  // Counter holds the number of DISPENSE cycles already spent without an ack.
  always_comb begin
    tmo_hit = (tmo_q == TMO_W'(DISP_TMO - 1));
    tmo_d   = ((state_q == DISPENSE) && (state_d == DISPENSE)) ? tmo_q + TMO_W'(1) : '0;
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  assign bus.disp_req    = disp_req_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: directed scenarios plus random traffic checked
// against a transaction-level vending model; honours VEND_DISP_TMO_EN.
`timescale 1ns/1ps
module tb_vend_ctrl;
  localparam int PA  = 15;
  localparam int PB  = 20;
  localparam int TMO = 63;
`ifdef VEND_DISP_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  vend_ctrl_if vif ();

  vend_ctrl #(
    .PRICE_A (PA),
    .PRICE_B (PB),
    .DISP_TMO(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (vif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       disp_req;
    logic       chg_req;
    logic       coin_reject;
    logic [4:0] credit;
    logic       busy;
    logic       fault;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a customer's money and what the machine is busy doing.
  int m_credit;
  bit m_dispensing;
  bit m_refunding;
  bit m_faulted;
  int m_wait;

  function automatic obs_t sample();
    obs_t o;
    o.disp_req    = vif.disp_req;
    o.chg_req     = vif.chg_req;
    o.coin_reject = vif.coin_reject;
    o.credit      = vif.credit;
    o.busy        = vif.busy;
    o.fault       = vif.fault;
    return o;
  endfunction

  task automatic report(input string name, input obs_t a, input obs_t e);
    $display("FAIL %s: got dreq=%0b creq=%0b rej=%0b credit=%0d busy=%0b fault=%0b, want dreq=%0b creq=%0b rej=%0b credit=%0d busy=%0b fault=%0b (t=%0t)",
             name, a.disp_req, a.chg_req, a.coin_reject, a.credit, a.busy, a.fault,
             e.disp_req, e.chg_req, e.coin_reject, e.credit, e.busy, e.fault, $time);
  endtask

  task automatic model_step(input bit c5, input bit c10, input bit sa, input bit sb,
                            input bit can, input bit dack, input bit cack, output bit rej);
    int coins;
    bit was_busy;
    bit shopping;
    coins    = (c5 ? 5 : 0) + (c10 ? 10 : 0);
    was_busy = m_dispensing || m_refunding || m_faulted;
    shopping = !was_busy && (m_credit > 0);
    rej      = 1'b0;
    if (was_busy)                  rej = (coins != 0);
    else if (m_credit + coins > 30) rej = 1'b1;
    else                            m_credit = m_credit + coins;

    if (shopping) begin
      if (sa && m_credit >= PA) begin
        m_credit     = m_credit - PA;
        m_dispensing = 1'b1;
        m_wait       = 0;
      end else if (sb && m_credit >= PB) begin
        m_credit     = m_credit - PB;
        m_dispensing = 1'b1;
        m_wait       = 0;
      end else if (can) begin
        m_refunding = 1'b1;
      end
    end else if (m_dispensing) begin
      if (dack) begin
        m_dispensing = 1'b0;
        m_refunding  = (m_credit > 0);
      end else begin
        m_wait = m_wait + 1;
        if (TMO_EN && m_wait >= TMO) begin
          m_dispensing = 1'b0;
          m_faulted    = 1'b1;
        end
      end
    end else if (m_refunding && cack) begin
      m_credit = m_credit - 5;
      if (m_credit == 0) m_refunding = 1'b0;
    end
  endtask

  task automatic cyc(input bit c5, input bit c10, input bit sa, input bit sb,
                     input bit can, input bit dack, input bit cack);
    bit   rej;
    obs_t e;
    @(negedge clk);
    vif.coin_5   = c5;
    vif.coin_10  = c10;
    vif.sel_a    = sa;
    vif.sel_b    = sb;
    vif.cancel   = can;
    vif.disp_ack = dack;
    vif.chg_ack  = cack;
    model_step(c5, c10, sa, sb, can, dack, cack, rej);
    e.disp_req    = m_dispensing;
    e.chg_req     = m_refunding;
    e.coin_reject = rej;
    e.credit      = 5'(m_credit);
    e.busy        = m_dispensing || m_refunding || m_faulted;
    e.fault       = m_faulted;
    exp_q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_inputs();
    vif.coin_5   = 1'b0;
    vif.coin_10  = 1'b0;
    vif.sel_a    = 1'b0;
    vif.sel_b    = 1'b0;
    vif.cancel   = 1'b0;
    vif.disp_ack = 1'b0;
    vif.chg_ack  = 1'b0;
  endtask

  // Reset lands mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    obs_t a;
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    a = sample();
    total++;
    if (a !== '0) begin
      bad++;
      report("reset_outputs", a, '0);
    end
    m_credit     = 0;
    m_dispensing = 1'b0;
    m_refunding  = 1'b0;
    m_faulted    = 1'b0;
    m_wait       = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = sample();
        total++;
        if (a !== e) begin
          bad++;
          report("outputs", a, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL sim_timeout: got still running, want finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    idle_inputs();
    do_reset();

    // Exact sale, no change.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    nop(3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    nop(2);

    // Sale with one coin of change; stray acks outside their requests.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 1);
    nop(1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    nop(2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    nop(2);

    // Overflow rejections at 25 and at 20 with both coins.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    nop(1);

    // Insufficient selection ignored, then refund; coin + selection same cycle.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    nop(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    nop(2);

    // Reset while dispensing.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    nop(2);
    do_reset();

    // Dispenser never acknowledges.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    nop(TMO + 4);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    nop(3);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) == 499 || (m_faulted && $urandom_range(9) == 0)) do_reset();
      cyc($urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom_range(7) == 0, $urandom_range(7) == 0,
          $urandom_range(19) == 0, $urandom_range(5) == 0,
          $urandom_range(2) == 0);
    end

    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
